// File: rtl/key_lut_mux_pkg.sv
// Shared constants and helpers for the key-indexed lookup multiplexer.
package key_lut_mux_pkg;

    localparam int OUT_COMB       = 0;
    localparam int OUT_REGISTERED = 1;

    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/key_lut_mux.sv
// Key-indexed lookup: ORs together the data of every {key,data} pair whose key
// equals the select key, with an optional single output register stage.
module key_lut_mux
    import key_lut_mux_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1,
    parameter int OUT_REG  = OUT_COMB
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [KEY_LEN-1:0]                     key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
    output logic [DATA_LEN-1:0]                    out,
    output logic                                   hit
);

    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

    logic [NR_KEY-1:0]   match;
    logic [DATA_LEN-1:0] masked [NR_KEY];
    logic [DATA_LEN-1:0] result;
    logic                hit_c;

    for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
        logic [PAIR_LEN-1:0] pair;
        assign pair      = lut[PAIR_LEN*i +: PAIR_LEN];
        assign match[i]  = (pair[PAIR_LEN-1:DATA_LEN] == key);
        assign masked[i] = pair[DATA_LEN-1:0] & {DATA_LEN{match[i]}};
    end

    // No priority: duplicate keys merge their data bitwise.
    always_comb begin
        result = '0;
        hit_c  = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            result = result | masked[i];
            hit_c  = hit_c | match[i];
        end
    end

    if (OUT_REG == OUT_REGISTERED) begin : g_reg
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                out <= '0;
                hit <= 1'b0;
            end else begin
                out <= result;
                hit <= hit_c;
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk_i, rst_i};
        assign out = result;
        assign hit = hit_c;
    end

endmodule

// File: tb/tb_key_lut_mux.sv
// Directed and swept checks of key_lut_mux in several parameterisations.
module tb_key_lut_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // 4 pairs, 2-bit key, 8-bit data, combinational
    logic [1:0]  key1;
    logic [39:0] lut1;
    logic [7:0]  out1;
    logic        hit1;
    key_lut_mux #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .OUT_REG(0)) u1 (
        .clk_i(clk), .rst_i(rst), .key(key1), .lut(lut1), .out(out1), .hit(hit1));

    // 2 pairs, 1-bit key, 4-bit data (strobe select)
    logic        key2;
    logic [9:0]  lut2;
    logic [3:0]  out2;
    logic        hit2;
    key_lut_mux #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(4), .OUT_REG(0)) u2 (
        .clk_i(clk), .rst_i(rst), .key(key2), .lut(lut2), .out(out2), .hit(hit2));

    // 4 pairs, 3-bit key, 4-bit data, both output modes share inputs
    logic [2:0]  key3;
    logic [27:0] lut3;
    logic [3:0]  out3, out3r;
    logic        hit3, hit3r;
    key_lut_mux #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4), .OUT_REG(0)) u3 (
        .clk_i(clk), .rst_i(rst), .key(key3), .lut(lut3), .out(out3), .hit(hit3));
    key_lut_mux #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4), .OUT_REG(1)) u3r (
        .clk_i(clk), .rst_i(rst), .key(key3), .lut(lut3), .out(out3r), .hit(hit3r));

    // 2 pairs, 2-bit key, 8-bit data (duplicate keys)
    logic [1:0]  key4;
    logic [19:0] lut4;
    logic [7:0]  out4;
    logic        hit4;
    key_lut_mux #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8), .OUT_REG(0)) u4 (
        .clk_i(clk), .rst_i(rst), .key(key4), .lut(lut4), .out(out4), .hit(hit4));

    // Registered version of the first configuration
    logic [1:0]  key5;
    logic [39:0] lut5;
    logic [7:0]  out5;
    logic        hit5;
    logic        rst5;
    key_lut_mux #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .OUT_REG(1)) u5 (
        .clk_i(clk), .rst_i(rst5), .key(key5), .lut(lut5), .out(out5), .hit(hit5));

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference for the 3-bit-key configuration: returns {hit, data}.
    function automatic logic [4:0] ref3(input logic [27:0] l, input logic [2:0] k);
        logic [3:0] d;
        logic       h;
        logic [6:0] p;
        d = '0;
        h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = l[7*i +: 7];
            if (p[6:4] == k) begin
                d = d | p[3:0];
                h = 1'b1;
            end
        end
        return {h, d};
    endfunction

    logic [7:0] exp1 [4];
    int         perm [8];
    logic [4:0] exp3;
    logic [3:0] pend_out;
    logic       pend_hit;

    initial begin
        rst  = 1'b1;
        rst5 = 1'b1;
        key1 = '0; key2 = '0; key3 = '0; key4 = '0; key5 = '0;
        lut1 = '0; lut2 = '0; lut3 = '0; lut4 = '0; lut5 = '0;

        // Reset state of the registered instances
        @(posedge clk); #1;
        check("rst_out5", 32'(out5), 32'h00);
        check("rst_hit5", 32'(hit5), 32'h0);
        check("rst_out3r", 32'(out3r), 32'h0);
        check("rst_hit3r", 32'(hit3r), 32'h0);

        // Four-way select, zero latency
        lut1 = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
        exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33; exp1[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            key1 = 2'(k);
            #1;
            check($sformatf("sel4_out_k%0d", k), 32'(out1), 32'(exp1[k]));
            check($sformatf("sel4_hit_k%0d", k), 32'(hit1), 32'h1);
        end

        // Half-strobe select
        lut2 = {1'b0, 4'b0011, 1'b1, 4'b1100};
        key2 = 1'b0; #1;
        check("strobe_out_k0", 32'(out2), 32'h3);
        check("strobe_hit_k0", 32'(hit2), 32'h1);
        key2 = 1'b1; #1;
        check("strobe_out_k1", 32'(out2), 32'hC);
        check("strobe_hit_k1", 32'(hit2), 32'h1);

        // Miss returns zero and no hit
        lut3 = {3'd0, 4'h1, 3'd1, 4'h2, 3'd2, 4'h4, 3'd3, 4'h8};
        key3 = 3'd2; #1;
        check("miss_tbl_out_k2", 32'(out3), 32'h4);
        check("miss_tbl_hit_k2", 32'(hit3), 32'h1);
        key3 = 3'd6; #1;
        check("miss_out_k6", 32'(out3), 32'h0);
        check("miss_hit_k6", 32'(hit3), 32'h0);
        key3 = 3'd7; #1;
        check("miss_out_k7", 32'(out3), 32'h0);
        check("miss_hit_k7", 32'(hit3), 32'h0);

        // Duplicate keys merge
        lut4 = {2'b01, 8'h0F, 2'b01, 8'hF0};
        key4 = 2'b01; #1;
        check("dup_out", 32'(out4), 32'hFF);
        check("dup_hit", 32'(hit4), 32'h1);
        key4 = 2'b10; #1;
        check("dup_miss_out", 32'(out4), 32'h00);
        check("dup_miss_hit", 32'(hit4), 32'h0);

        // Registered output: one-cycle latency and synchronous reset
        @(negedge clk);
        rst  = 1'b0;
        rst5 = 1'b0;
        lut5 = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
        key5 = 2'b01;
        #1;
        check("reg_hold_before_first", 32'(out5), 32'h00);
        @(posedge clk); #1;
        check("reg_out_k1", 32'(out5), 32'h22);
        check("reg_hit_k1", 32'(hit5), 32'h1);
        @(negedge clk);
        key5 = 2'b10;
        #1;
        check("reg_old_before_edge", 32'(out5), 32'h22);
        @(posedge clk); #1;
        check("reg_out_k2", 32'(out5), 32'h33);
        check("reg_hit_k2", 32'(hit5), 32'h1);
        @(negedge clk);
        rst5 = 1'b1;
        key5 = 2'b11;
        @(posedge clk); #1;
        check("reg_rst_out", 32'(out5), 32'h00);
        check("reg_rst_hit", 32'(hit5), 32'h0);
        @(negedge clk);
        rst5 = 1'b0;
        @(posedge clk); #1;
        check("reg_after_rst_out", 32'(out5), 32'h44);
        check("reg_after_rst_hit", 32'(hit5), 32'h1);
        @(negedge clk);
        lut5 = {2'b00, 8'hA5, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
        key5 = 2'b00;
        @(posedge clk); #1;
        check("reg_new_lut_out", 32'(out5), 32'hA5);

        // Key sweep over random unique-key tables, both output modes
        for (int trial = 0; trial < 3; trial++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(i, 0));
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                lut3[7*i +: 7] = {3'(perm[i]), 4'($urandom)};
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                key3 = 3'(k);
                #1;
                exp3 = ref3(lut3, key3);
                check($sformatf("sweep%0d_out_k%0d", trial, k), 32'(out3), 32'(exp3[3:0]));
                check($sformatf("sweep%0d_hit_k%0d", trial, k), 32'(hit3), 32'(exp3[4]));
                pend_out = exp3[3:0];
                pend_hit = exp3[4];
                @(posedge clk); #1;
                check($sformatf("sweep%0d_rout_k%0d", trial, k), 32'(out3r), 32'(pend_out));
                check($sformatf("sweep%0d_rhit_k%0d", trial, k), 32'(hit3r), 32'(pend_hit));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
